seqgen: RTL and testbench

- Programmable pulse-train generator: the transmit side of the sequence-check path. It drives `out_sig` with N rising edges of configurable high and low widths.
- Used as the stimulus source for, and in-system counterpart of, the sliding-window rise-count checker.
- Software or a controller pulses `start` with a configuration. The block emits the train, then raises a one-cycle `done`.
- Single clock domain; `out_sig` is registered and glitch-free.

---
 rtl/seq_pkg.sv | 12 +
 rtl/seqgen_phase_cnt.sv | 32 +++
 rtl/seqgen.sv | 138 +++++++++++++
 tb/tb_seqgen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the pulse-train generator and its checker bench.
package seq_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_FIN  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/seqgen_phase_cnt.sv
// Loadable phase down-counter: loads len-1 (a zero length is treated as 1) and stops at 0.
module seqgen_phase_cnt
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             zero_o
);
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = (len_i == '0) ? '0 : len_i - ONE;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/seqgen.sv
// Programmable pulse-train generator: N rising edges of H-cycle highs separated by L-cycle lows.
module seqgen
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             out_sig,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);
  localparam logic [NUM_W-1:0] P_ONE = 1;

  seq_state_t       state_q, state_d;
  logic             out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d, n_q, n_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d, ld_len;
  logic             ld, dec, ph_zero;

  seqgen_phase_cnt #(.CNT_W(CNT_W)) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .dec_i  (dec),
    .len_i  (ld_len),
    .zero_o (ph_zero)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pcnt_d  = pcnt_q;
    n_d     = n_q;
    h_d     = h_q;
    l_d     = l_q;
    ld      = 1'b0;
    dec     = 1'b0;
    ld_len  = h_q;
    case (state_q)
      S_IDLE: if (start) begin
        n_d = num_pulses;
        h_d = high_len;
        l_d = low_len;
        if (num_pulses != '0) begin
          // Config registers update on this same edge, so load from the ports.
          state_d = S_HIGH;
          out_d   = 1'b1;
          busy_d  = 1'b1;
          pcnt_d  = P_ONE;
          ld      = 1'b1;
          ld_len  = high_len;
        end else begin
          state_d = S_FIN;
          pcnt_d  = '0;
          done_d  = 1'b1;
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (ph_zero) begin
          out_d = 1'b0;
          if (pcnt_q < n_q) begin
            state_d = S_LOW;
            ld      = 1'b1;
            ld_len  = l_q;
          end else begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          dec = 1'b1;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (ph_zero) begin
          state_d = S_HIGH;
          out_d   = 1'b1;
          pcnt_d  = pcnt_q + P_ONE;
          ld      = 1'b1;
          ld_len  = h_q;
        end else begin
          dec = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
      n_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
      n_q     <= n_d;
      h_q     <= h_d;
      l_q     <= l_d;
    end
  end

  assign out_sig   = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pcnt_q;
endmodule

// File: tb/tb_seqgen.sv
// Directed bench for seqgen: per-cycle waveform capture compared against hand-computed bit masks.
module tb_seqgen;
  import seq_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [3:0] num_pulses = '0;
  logic [7:0] high_len = '0, low_len = '0;
  logic       out_sig, busy, done;
  logic [3:0] pulse_cnt;

  int nchk = 0, npass = 0;

  seqgen #(.CNT_W(CNT_W_DEF), .NUM_W(NUM_W_DEF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_pulses (num_pulses),
    .high_len   (high_len),
    .low_len    (low_len),
    .out_sig    (out_sig),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Bit c of each vector holds the signal in cycle c (start is sampled on edge 0).
  // hits counts entries into "3+ rises within the last 5 cycles" (checker loopback model).
  task automatic run(input logic [3:0] n, input logic [7:0] h, input logic [7:0] l,
                     input int ncyc, input int abort_c, input int rs_c, input int again_c,
                     output logic [31:0] vo, output logic [31:0] vb, output logic [31:0] vd,
                     output int hits);
    logic       prev, above;
    logic [4:0] hist;
    int         cnt;
    vo = '0; vb = '0; vd = '0; hits = 0;
    prev = 1'b0; above = 1'b0; hist = '0;
    num_pulses = n; high_len = h; low_len = l; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      vo[c] = out_sig; vb[c] = busy; vd[c] = done;
      hist = {hist[3:0], out_sig & ~prev};
      prev = out_sig;
      cnt = $countones(hist);
      if (cnt >= 3 && !above) hits++;
      above = (cnt >= 3);
      start = 1'b0;
      abort = (c == abort_c);
      if (c == rs_c) begin
        start = 1'b1; num_pulses = 4'd7; high_len = 8'd5; low_len = 8'd5;
      end
      if (again_c != 0 && (c == again_c || c == again_c - 1)) begin
        start = 1'b1; num_pulses = 4'd1; high_len = 8'd1; low_len = 8'd1;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  logic [31:0] vo, vb, vd, acc;
  int          hits;

  initial begin
    #2;
    chk("rst_out", 32'(out_sig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pcnt", 32'(pulse_cnt), 32'd0);
    #1 rst_n = 1'b1;
    idle(2);

    // N=3 H=2 L=3: highs in 1-2, 6-7, 11-12; done at 13
    run(4'd3, 8'd2, 8'd3, 16, 0, 0, 0, vo, vb, vd, hits);
    chk("t1_out", vo, 32'h0000_18C6);
    chk("t1_busy", vb, 32'h0000_1FFE);
    chk("t1_done", vd, 32'h0000_2000);
    chk("t1_pcnt", 32'(pulse_cnt), 32'd3);
    idle(2);

    // N=1 with zero lengths clamped to 1
    run(4'd1, 8'd0, 8'd0, 6, 0, 0, 0, vo, vb, vd, hits);
    chk("t2_out", vo, 32'h0000_0002);
    chk("t2_busy", vb, 32'h0000_0002);
    chk("t2_done", vd, 32'h0000_0004);
    chk("t2_pcnt", 32'(pulse_cnt), 32'd1);
    idle(2);

    // N=0: done only
    run(4'd0, 8'd4, 8'd4, 5, 0, 0, 0, vo, vb, vd, hits);
    chk("t3_out", vo, 32'h0);
    chk("t3_busy", vb, 32'h0);
    chk("t3_done", vd, 32'h0000_0002);
    chk("t3_pcnt", 32'(pulse_cnt), 32'd0);
    idle(2);

    // N=4 H=1 L=1, abort sampled during 2nd low (cycle 4)
    run(4'd4, 8'd1, 8'd1, 12, 4, 0, 0, vo, vb, vd, hits);
    chk("t4_out", vo, 32'h0000_000A);
    chk("t4_busy", vb, 32'h0000_001E);
    chk("t4_done", vd, 32'h0);
    chk("t4_pcnt", 32'(pulse_cnt), 32'd2);
    idle(2);

    // Restart mid-train ignored; start in FIN ignored; start after done begins next train
    run(4'd3, 8'd2, 8'd3, 18, 0, 3, 14, vo, vb, vd, hits);
    chk("t5_out", vo, 32'h0000_98C6);
    chk("t5_busy", vb, 32'h0000_9FFE);
    chk("t5_done", vd, 32'h0001_2000);
    chk("t5_pcnt", 32'(pulse_cnt), 32'd1);
    idle(2);

    // Loopback window model (WINDOW=5, THRESHOLD=3)
    run(4'd3, 8'd1, 8'd1, 12, 0, 0, 0, vo, vb, vd, hits);
    chk("lb_dense_hits", 32'(hits), 32'd1);
    chk("lb_dense_out", vo, 32'h0000_002A);
    idle(2);
    run(4'd3, 8'd1, 8'd4, 16, 0, 0, 0, vo, vb, vd, hits);
    chk("lb_sparse_hits", 32'(hits), 32'd0);
    chk("lb_sparse_out", vo, 32'h0000_0842);
    idle(2);

    // Asynchronous reset mid-train
    num_pulses = 4'd3; high_len = 8'd4; low_len = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mr_pre_out", 32'(out_sig), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_out", 32'(out_sig), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_pcnt", 32'(pulse_cnt), 32'd0);
    #1 rst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      acc = acc | {29'd0, done, busy, out_sig};
    end
    chk("mr_quiet", acc, 32'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
